// File: rtl/key_check_if.sv
// Keypad-side bundle for key_check: entered byte stream, stored bank
// and the attempt result/lockout status returned to the unlock logic.
interface key_check_if #(
  parameter int KEY_W    = 8,
  parameter int MAX_KEYS = 4
);
  logic [KEY_W-1:0]          din;
  logic                      dvalid;
  logic                      abort;
  logic [KEY_W*MAX_KEYS-1:0] keys;
  logic [3:0]                num_keys;
  logic                      busy;
  logic                      match;
  logic                      fail;
  logic                      locked;
  logic [1:0]                fail_cnt;

  modport master (
    output din, dvalid, abort, keys, num_keys,
    input  busy, match, fail, locked, fail_cnt
  );

  modport slave (
    input  din, dvalid, abort, keys, num_keys,
    output busy, match, fail, locked, fail_cnt
  );
endinterface

// File: rtl/key_check.sv
// Key entry checker: compares an entered byte sequence against the
// latched key bank, pulses match/fail and enforces a timed lockout.
module key_check #(
  parameter int KEY_W       = 8,
  parameter int MAX_KEYS    = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input logic        dclk,
  input logic        reset,
  key_check_if.slave bus
);

  localparam int IW = $clog2(MAX_KEYS + 1);
  localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int BW = KEY_W * MAX_KEYS;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    RESULT,
    LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   n_q, n_d;
  logic            mis_q, mis_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic [CW-1:0]   lcnt_q, lcnt_d;
  logic            busy_q, busy_d;
  logic            match_q, match_d;
  logic            fail_q, fail_d;
  logic            locked_q, locked_d;
  logic [1:0]      fcnt_q, fcnt_d;

  logic [3:0]      nk_c;
  logic [IW-1:0]   n_in;
  logic [KEY_W-1:0] slot;
  logic [1:0]      fcnt_inc;
  logic            fin;
  logic            mis_new;

  assign nk_c = (bus.num_keys > 4'(MAX_KEYS)) ?
                4'(MAX_KEYS) : bus.num_keys;
  assign n_in = nk_c[IW-1:0];
  assign slot = bank_q[32'(idx_q)*KEY_W +: KEY_W];
  assign fcnt_inc = (fcnt_q == 2'(MAX_FAILS)) ?
                    fcnt_q : fcnt_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    mis_d    = mis_q;
    bank_d   = bank_q;
    lcnt_d   = lcnt_q;
    locked_d = locked_q;
    fcnt_d   = fcnt_q;
    match_d  = 1'b0;
    fail_d   = 1'b0;
    fin      = 1'b0;
    mis_new  = mis_q;

    unique case (state_q)
      IDLE: begin
        if (bus.dvalid && nk_c != 4'd0 && !bus.abort) begin
          bank_d  = bus.keys;
          n_d     = n_in;
          mis_new = (bus.din != bus.keys[KEY_W-1:0]);
          mis_d   = mis_new;
          idx_d   = IW'(1);
          if (n_in == IW'(1)) fin = 1'b1;
          else                state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.dvalid) begin
          mis_new = mis_q | (bus.din != slot);
          mis_d   = mis_new;
          idx_d   = idx_q + IW'(1);
          if (idx_q == n_q - IW'(1)) fin = 1'b1;
        end
      end
      RESULT: begin
        state_d = locked_q ? LOCKOUT : IDLE;
      end
      LOCKOUT: begin
        state_d = LOCKOUT;
      end
      default: state_d = IDLE;
    endcase

    // Pulse and lockout decision land on the edge accepting the last byte
    if (fin) begin
      state_d = RESULT;
      if (!mis_new) begin
        match_d = 1'b1;
        fcnt_d  = 2'd0;
      end else begin
        fail_d = 1'b1;
        fcnt_d = fcnt_inc;
        if (fcnt_inc == 2'(MAX_FAILS)) begin
          locked_d = 1'b1;
          lcnt_d   = CW'(LOCK_CYCLES - 1);
        end
      end
    end

    // Lockout period is counted from the rise of locked
    if (locked_q) begin
      if (lcnt_q == '0) begin
        locked_d = 1'b0;
        fcnt_d   = 2'd0;
        state_d  = IDLE;
      end else begin
        lcnt_d = lcnt_q - CW'(1);
      end
    end
  end

  assign busy_d = (state_d == COMPARE);

  always_ff @(posedge dclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      n_q      <= '0;
      mis_q    <= 1'b0;
      bank_q   <= '0;
      lcnt_q   <= '0;
      busy_q   <= 1'b0;
      match_q  <= 1'b0;
      fail_q   <= 1'b0;
      locked_q <= 1'b0;
      fcnt_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      n_q      <= n_d;
      mis_q    <= mis_d;
      bank_q   <= bank_d;
      lcnt_q   <= lcnt_d;
      busy_q   <= busy_d;
      match_q  <= match_d;
      fail_q   <= fail_d;
      locked_q <= locked_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.match    = match_q;
  assign bus.fail     = fail_q;
  assign bus.locked   = locked_q;
  assign bus.fail_cnt = fcnt_q;

endmodule
